// File: rtl/vram_arbiter_if.sv
// Display, CPU and VRAM-macro signals around vram_arbiter; slave = arbiter side.
interface vram_arbiter_if;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic        vid_valid;
    logic [31:0] vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        mem_rd;
    logic [3:0]  mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, mem_rdata,
        output vid_valid, vid_data, cpu_busy, cpu_ack, cpu_dout,
               mem_rd, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, mem_rdata,
        input  vid_valid, vid_data, cpu_busy, cpu_ack, cpu_dout,
               mem_rd, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM slot arbiter: video > CPU read (buffer empty) > write drain; VRAM_WBUF_EN enables posted writes.
// Latency: video 2 cycles fixed, unobstructed CPU read/unbuffered write 2 cycles.
// Backpressure: registered cpu_busy; strobes arriving while busy are dropped.
module vram_arbiter #(
    parameter int WBUF_DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    vram_arbiter_if.slave bus
);

    typedef struct packed {
        logic [1:0]  plane;
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_ent_t;

    if (WBUF_DEPTH < 2 || WBUF_DEPTH > 8 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vram_arbiter: WBUF_DEPTH must be a power of two in 2..8");
    end

    logic        vid_pend;
    logic [12:0] vid_pend_addr;
    logic        rd_pend;
    logic        rd_pend_d;
    logic [14:0] rd_addr_q;
    logic        in_flight;
    logic        tag_cpu;
    logic        busy_q;
    logic        busy_d;
    logic        rd_go;
    logic        wr_go;
    logic        wr_ack;
    logic        rd_ack;
    logic        wr_accept;
    logic        rd_accept;
    wr_ent_t     wr_head;
    wr_ent_t     wr_new;

    assign wr_accept = bus.cpu_req & ~busy_q & bus.cpu_we;
    assign rd_accept = bus.cpu_req & ~busy_q & ~bus.cpu_we;
    assign wr_new    = {bus.cpu_addr[14:13], bus.cpu_addr[12:0], bus.cpu_din};
    assign rd_pend_d = rd_accept | (rd_pend & ~rd_go);

`ifdef VRAM_WBUF_EN
    localparam int AW = $clog2(WBUF_DEPTH);

    wr_ent_t       wbuf [WBUF_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_d;

    // Reads wait for an empty buffer, which gives read-after-write ordering.
    assign wr_head = wbuf[rd_ptr];
    assign rd_go   = rd_pend & ~vid_pend & (count == '0);
    assign wr_go   = ~vid_pend & (count != '0);
    assign count_d = count + {{AW{1'b0}}, wr_accept} - {{AW{1'b0}}, wr_go};
    assign busy_d  = (count_d == (AW+1)'(WBUF_DEPTH)) | rd_pend_d;
    assign wr_ack  = 1'b0;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
            if (wr_go)     rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_accept) wbuf[wr_ptr] <= wr_new;
    end
`else
    logic    wr_pend;
    logic    wr_ack_q;
    wr_ent_t wr_ent_q;

    assign wr_head = wr_ent_q;
    assign rd_go   = rd_pend & ~vid_pend;
    assign wr_go   = wr_pend & ~vid_pend;
    assign busy_d  = rd_pend_d | wr_accept | (wr_pend & ~wr_go);
    assign wr_ack  = wr_ack_q & ~reset;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_pend  <= 1'b0;
            wr_ack_q <= 1'b0;
            wr_ent_q <= '0;
        end else begin
            wr_pend  <= wr_accept | (wr_pend & ~wr_go);
            wr_ack_q <= wr_go;
            if (wr_accept) wr_ent_q <= wr_new;
        end
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vid_pend      <= 1'b0;
            vid_pend_addr <= '0;
            rd_pend       <= 1'b0;
            rd_addr_q     <= '0;
            in_flight     <= 1'b0;
            tag_cpu       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // Video is always issued the slot after its strobe, so a new strobe simply replaces it.
            vid_pend <= bus.vid_req;
            if (bus.vid_req) vid_pend_addr <= bus.vid_addr;
            rd_pend <= rd_pend_d;
            if (rd_accept) rd_addr_q <= bus.cpu_addr;
            in_flight <= vid_pend | rd_go;
            tag_cpu   <= rd_go;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        bus.mem_rd    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!reset) begin
            if (vid_pend) begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = vid_pend_addr;
            end else if (rd_go) begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = rd_addr_q[12:0];
            end else if (wr_go) begin
                bus.mem_we    = 4'b0001 << wr_head.plane;
                bus.mem_addr  = wr_head.addr;
                bus.mem_wdata = {4{wr_head.data}};
            end
        end
    end

    assign rd_ack        = in_flight & tag_cpu & ~reset;
    assign bus.vid_valid = in_flight & ~tag_cpu & ~reset;
    assign bus.vid_data  = bus.vid_valid ? bus.mem_rdata : '0;
    assign bus.cpu_ack   = rd_ack | wr_ack;
    assign bus.cpu_dout  = rd_ack ? bus.mem_rdata[{rd_addr_q[14:13], 3'b000} +: 8] : '0;
    assign bus.cpu_busy  = busy_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency VRAM model.
module tb_vram_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   nchecks = 0;
    int   nerrors = 0;
    logic [31:0] vram [8192];

    always #5 clk = ~clk;

    vram_arbiter_if bus();

    vram_arbiter #(.WBUF_DEPTH(4)) dut (
        .clk_sys(clk),
        .reset  (reset),
        .bus    (bus)
    );

    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_rd ? vram[bus.mem_addr] : 32'hDEAD_BEEF;
        for (int p = 0; p < 4; p++)
            if (bus.mem_we[p]) vram[bus.mem_addr][8*p +: 8] <= bus.mem_wdata[8*p +: 8];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vid_req  = 1'b0;
        bus.vid_addr = '0;
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_din  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        #4;
        nchecks++; if ({bus.mem_rd, bus.mem_we, bus.vid_valid, bus.cpu_busy, bus.cpu_ack} !== 8'h00) begin nerrors++; $display("FAIL reset_strobes: got %b want 0", {bus.mem_rd, bus.mem_we, bus.vid_valid, bus.cpu_busy, bus.cpu_ack}); end
        nchecks++; if ({bus.mem_addr, bus.mem_wdata} !== 45'h0) begin nerrors++; $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
        nchecks++; if ({bus.vid_data, bus.cpu_dout} !== 40'h0) begin nerrors++; $display("FAIL reset_data: got %h want 0", {bus.vid_data, bus.cpu_dout}); end
    endtask

    task automatic test_video();
        step(); bus.vid_req = 1'b1; bus.vid_addr = 13'h0ABC; #4;
        nchecks++; if (bus.mem_rd !== 1'b0) begin nerrors++; $display("FAIL vid_early: got %b want 0", bus.mem_rd); end
        step(); bus.vid_req = 1'b0; #4;
        nchecks++; if (bus.mem_rd !== 1'b1) begin nerrors++; $display("FAIL vid_issue_rd: got %b want 1", bus.mem_rd); end
        nchecks++; if (bus.mem_addr !== 13'h0ABC) begin nerrors++; $display("FAIL vid_issue_addr: got %h want 0abc", bus.mem_addr); end
        step(); #4;
        nchecks++; if (bus.vid_valid !== 1'b1) begin nerrors++; $display("FAIL vid_valid: got %b want 1", bus.vid_valid); end
        nchecks++; if (bus.vid_data !== 32'h11223344) begin nerrors++; $display("FAIL vid_data: got %h want 11223344", bus.vid_data); end
        nchecks++; if (bus.mem_rd !== 1'b0) begin nerrors++; $display("FAIL vid_rd_once: got %b want 0", bus.mem_rd); end
        step(); #4;
        nchecks++; if (bus.vid_valid !== 1'b0) begin nerrors++; $display("FAIL vid_valid_pulse: got %b want 0", bus.vid_valid); end
    endtask

    task automatic test_raw();
        step(); bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = {2'd2, 13'h0100}; bus.cpu_din = 8'h5A; #4;
        step(); bus.cpu_we = 1'b0; #4;
        nchecks++; if (bus.mem_we !== 4'b0100) begin nerrors++; $display("FAIL raw_we: got %b want 0100", bus.mem_we); end
        nchecks++; if (bus.mem_addr !== 13'h0100) begin nerrors++; $display("FAIL raw_we_addr: got %h want 0100", bus.mem_addr); end
        nchecks++; if (bus.mem_wdata !== 32'h5A5A5A5A) begin nerrors++; $display("FAIL raw_wdata: got %h want 5a5a5a5a", bus.mem_wdata); end
`ifdef VRAM_WBUF_EN
        step(); bus.cpu_req = 1'b0; #4;
`else
        nchecks++; if (bus.cpu_busy !== 1'b1) begin nerrors++; $display("FAIL raw_wr_busy: got %b want 1", bus.cpu_busy); end
        step(); #4;
        nchecks++; if ({bus.cpu_ack, bus.cpu_busy, bus.mem_rd} !== 3'b100) begin nerrors++; $display("FAIL raw_wr_ack: got %b want 100", {bus.cpu_ack, bus.cpu_busy, bus.mem_rd}); end
        step(); bus.cpu_req = 1'b0; #4;
`endif
        nchecks++; if ({bus.mem_rd, bus.mem_we} !== 5'b10000) begin nerrors++; $display("FAIL raw_rd: got %b want 10000", {bus.mem_rd, bus.mem_we}); end
        nchecks++; if (bus.mem_addr !== 13'h0100) begin nerrors++; $display("FAIL raw_rd_addr: got %h want 0100", bus.mem_addr); end
        step(); #4;
        nchecks++; if (bus.cpu_ack !== 1'b1) begin nerrors++; $display("FAIL raw_ack: got %b want 1", bus.cpu_ack); end
        nchecks++; if (bus.cpu_dout !== 8'h5A) begin nerrors++; $display("FAIL raw_dout: got %h want 5a", bus.cpu_dout); end
        nchecks++; if (bus.cpu_busy !== 1'b0) begin nerrors++; $display("FAIL raw_busy_fall: got %b want 0", bus.cpu_busy); end
    endtask

    task automatic test_vid_cpu_same();
        step();
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0ABC;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = {2'd0, 13'h1FFF};
        #4;
        step(); idle_inputs(); #4;
        nchecks++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 13'h0ABC}) begin nerrors++; $display("FAIL same_vid_rd: got %h want 10abc", {bus.mem_rd, bus.mem_addr}); end
        nchecks++; if (bus.cpu_busy !== 1'b1) begin nerrors++; $display("FAIL same_busy: got %b want 1", bus.cpu_busy); end
        step(); #4;
        nchecks++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 13'h1FFF}) begin nerrors++; $display("FAIL same_cpu_rd: got %h want 11fff", {bus.mem_rd, bus.mem_addr}); end
        nchecks++; if ({bus.vid_valid, bus.cpu_ack} !== 2'b10) begin nerrors++; $display("FAIL same_tag_vid: got %b want 10", {bus.vid_valid, bus.cpu_ack}); end
        nchecks++; if (bus.vid_data !== 32'h11223344) begin nerrors++; $display("FAIL same_vid_data: got %h want 11223344", bus.vid_data); end
        step(); #4;
        nchecks++; if ({bus.vid_valid, bus.cpu_ack} !== 2'b01) begin nerrors++; $display("FAIL same_tag_cpu: got %b want 01", {bus.vid_valid, bus.cpu_ack}); end
        nchecks++; if (bus.cpu_dout !== 8'h88) begin nerrors++; $display("FAIL same_cpu_dout: got %h want 88", bus.cpu_dout); end
    endtask

    task automatic test_reset_inflight();
        step(); bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = {2'd1, 13'h1FFF}; #4;
        step(); idle_inputs(); #4;
        nchecks++; if (bus.mem_rd !== 1'b1) begin nerrors++; $display("FAIL rstif_rd: got %b want 1", bus.mem_rd); end
        step(); reset = 1'b1; #4;
        nchecks++; if ({bus.cpu_ack, bus.vid_valid, bus.cpu_dout} !== 10'h0) begin nerrors++; $display("FAIL rstif_no_ack: got %h want 0", {bus.cpu_ack, bus.vid_valid, bus.cpu_dout}); end
        step(); reset = 1'b0; #4;
        nchecks++; if ({bus.cpu_busy, bus.cpu_ack, bus.mem_rd, bus.mem_we} !== 7'h0) begin nerrors++; $display("FAIL rstif_after: got %b want 0", {bus.cpu_busy, bus.cpu_ack, bus.mem_rd, bus.mem_we}); end
    endtask

    task automatic test_reset_discard();
        int we_cnt = 0;
        int ack_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            bus.vid_req  = (c < 3);
            bus.vid_addr = 13'h0010;
            bus.cpu_req  = (c < 2);
            bus.cpu_we   = 1'b1;
            bus.cpu_addr = {2'd0, 13'h0300 + 13'(c)};
            bus.cpu_din  = 8'h11;
            reset        = (c == 3);
            #4;
            if (c >= 3 && bus.mem_we != 4'b0000) we_cnt++;
            if (c >= 3 && bus.cpu_ack) ack_cnt++;
            if (c == 4) begin
                nchecks++; if (bus.cpu_busy !== 1'b0) begin nerrors++; $display("FAIL discard_busy: got %b want 0", bus.cpu_busy); end
            end
        end
        idle_inputs();
        nchecks++; if (we_cnt != 0) begin nerrors++; $display("FAIL discard_we_count: got %0d want 0", we_cnt); end
        nchecks++; if (ack_cnt != 0) begin nerrors++; $display("FAIL discard_ack_count: got %0d want 0", ack_cnt); end
    endtask

`ifdef VRAM_WBUF_EN
    task automatic test_burst();
        int we_cnt = 0;
        int bad_cnt = 0;
        int vv_cnt = 0;
        logic [3:0] exp_we;
        for (int c = 0; c < 16; c++) begin
            step();
            bus.vid_req  = (c <= 4) || (c == 8);
            bus.vid_addr = 13'h0020;
            bus.cpu_req  = (c <= 4);
            bus.cpu_we   = 1'b1;
            bus.cpu_addr = {c[1:0], 13'h0200 + 13'(c)};
            bus.cpu_din  = 8'h10 + 8'(c);
            #4;
            if (c == 3 || c == 4 || c == 6 || c == 7) begin
                nchecks++; if (bus.cpu_busy !== (c == 4 || c == 6)) begin nerrors++; $display("FAIL burst_busy_c%0d: got %b want %b", c, bus.cpu_busy, (c == 4 || c == 6)); end
            end
            if (bus.mem_we != 4'b0000) begin
                exp_we = 4'b0001 << we_cnt[1:0];
                if (bus.mem_addr == 13'h0204) bad_cnt++;
                nchecks++; if ({bus.mem_we, bus.mem_addr} !== {exp_we, 13'h0200 + 13'(we_cnt)}) begin nerrors++; $display("FAIL burst_drain%0d: got %h want %h", we_cnt, {bus.mem_we, bus.mem_addr}, {exp_we, 13'h0200 + 13'(we_cnt)}); end
                nchecks++; if (bus.mem_wdata !== {4{8'h10 + 8'(we_cnt)}}) begin nerrors++; $display("FAIL burst_wdata%0d: got %h want %h", we_cnt, bus.mem_wdata, {4{8'h10 + 8'(we_cnt)}}); end
                we_cnt++;
            end
            if (c == 9) begin
                nchecks++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 13'h0020}) begin nerrors++; $display("FAIL burst_vid_rd: got %h want 10020", {bus.mem_rd, bus.mem_addr}); end
            end
            if (c == 10) begin
                nchecks++; if (bus.vid_valid !== 1'b1) begin nerrors++; $display("FAIL burst_vid_lat: got %b want 1", bus.vid_valid); end
            end
            if (bus.vid_valid) vv_cnt++;
        end
        idle_inputs();
        nchecks++; if (we_cnt != 4) begin nerrors++; $display("FAIL burst_we_count: got %0d want 4", we_cnt); end
        nchecks++; if (bad_cnt != 0) begin nerrors++; $display("FAIL burst_fifth_dropped: got %0d want 0", bad_cnt); end
        nchecks++; if (vv_cnt != 6) begin nerrors++; $display("FAIL burst_vid_count: got %0d want 6", vv_cnt); end
    endtask
`else
    task automatic test_write_unbuf();
        step(); bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = {2'd1, 13'h0033}; bus.cpu_din = 8'hC7; #4;
        nchecks++; if (bus.cpu_busy !== 1'b0) begin nerrors++; $display("FAIL wr_busy_pre: got %b want 0", bus.cpu_busy); end
        step(); bus.cpu_addr = {2'd3, 13'h0044}; bus.cpu_din = 8'h99; #4;
        nchecks++; if (bus.cpu_busy !== 1'b1) begin nerrors++; $display("FAIL wr_busy: got %b want 1", bus.cpu_busy); end
        nchecks++; if ({bus.mem_we, bus.mem_addr} !== {4'b0010, 13'h0033}) begin nerrors++; $display("FAIL wr_issue: got %h want %h", {bus.mem_we, bus.mem_addr}, {4'b0010, 13'h0033}); end
        nchecks++; if (bus.mem_wdata !== 32'hC7C7C7C7) begin nerrors++; $display("FAIL wr_wdata: got %h want c7c7c7c7", bus.mem_wdata); end
        nchecks++; if (bus.cpu_ack !== 1'b0) begin nerrors++; $display("FAIL wr_ack_early: got %b want 0", bus.cpu_ack); end
        step(); idle_inputs(); #4;
        nchecks++; if ({bus.cpu_ack, bus.cpu_busy, bus.mem_we} !== 6'b100000) begin nerrors++; $display("FAIL wr_ack: got %b want 100000", {bus.cpu_ack, bus.cpu_busy, bus.mem_we}); end
        step(); #4;
        nchecks++; if ({bus.cpu_ack, bus.mem_we} !== 5'b00000) begin nerrors++; $display("FAIL wr_ignored: got %b want 00000", {bus.cpu_ack, bus.mem_we}); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8192; i++) vram[i] = 32'h0;
        vram[13'h0ABC] = 32'h11223344;
        vram[13'h0100] = 32'hA1B2C3D4;
        vram[13'h1FFF] = 32'h55667788;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_video();
        step();
        test_raw();
        step();
        test_vid_cpu_same();
        step();
        test_reset_inflight();
        step();
        test_reset_discard();
        step();
`ifdef VRAM_WBUF_EN
        test_burst();
`else
        test_write_unbuf();
`endif
        step();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
